brent_kung_pipe_adder: RTL

Parametrised, pipelined Brent-Kung adder/subtractor with a valid/ready handshake, signed-overflow and zero flags, and a pass-through tag. It extends the team's combinational 64-bit Brent-Kung adder to any power-of-two width. It adds an add/sub mode and a fixed 3-stage pipeline, so it can sit in registered datapaths between producers and consumers that may stall. Throughput is one operation per cycle when downstream is ready.

---
 rtl/brent_kung_pipe_adder.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/brent_kung_pipe_adder.sv
// Three-stage pipelined Brent-Kung adder/subtractor with valid/ready flow control.
// S1 registers operands, S2 registers the prefix up-sweep, S3 finishes carries and flags.
module brent_kung_pipe_adder #(
  parameter int WIDTH = 64,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic [TAG_W-1:0] out_tag
);

  localparam int LVL = $clog2(WIDTH);

  logic             adv1, adv2, adv3;
  logic             v1, v2, v3;
  logic [WIDTH-1:0] a1, b1;
  logic             cin1;
  logic [TAG_W-1:0] tag1;
  logic [WIDTH-1:0] g2, p2, pb2;
  logic             cin2;
  logic [TAG_W-1:0] tag2;
  logic [WIDTH-1:0] sum3;
  logic             cout3, ovf3, zero3;
  logic [TAG_W-1:0] tag3;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] gu, pu;
  logic [WIDTH-1:0] gd, pd, carry, sum_c;
  logic             cout_c, ovf_c;

  // A stage may load whenever it is empty or the stage after it is moving.
  assign adv3     = !v3 | out_ready;
  assign adv2     = !v2 | adv3;
  assign adv1     = !v1 | adv2;
  assign in_ready = adv1;

  assign b_eff = sub ? ~b : b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1   <= 1'b0;
      a1   <= '0;
      b1   <= '0;
      cin1 <= 1'b0;
      tag1 <= '0;
    end else if (adv1) begin
      v1   <= in_valid;
      a1   <= a;
      b1   <= b_eff;
      cin1 <= cin;
      tag1 <= in_tag;
    end
  end

  // Up-sweep in place: level k only rewrites nodes whose partner is untouched at that level.
  always_comb begin
    gu = a1 & b1;
    pu = a1 ^ b1;
    for (int k = 1; k <= LVL; k++) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (((i + 1) % (1 << k)) == 0) begin
          gu[i] = gu[i] | (pu[i] & gu[i - (1 << (k - 1))]);
          pu[i] = pu[i] & pu[i - (1 << (k - 1))];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2   <= 1'b0;
      g2   <= '0;
      p2   <= '0;
      pb2  <= '0;
      cin2 <= 1'b0;
      tag2 <= '0;
    end else if (adv2) begin
      v2   <= v1;
      g2   <= gu;
      p2   <= pu;
      pb2  <= a1 ^ b1;
      cin2 <= cin1;
      tag2 <= tag1;
    end
  end

  // Down-sweep turns every node into a prefix over bits 0..i; cin is folded in afterwards.
  always_comb begin
    gd    = g2;
    pd    = p2;
    carry = '0;
    for (int k = LVL - 1; k >= 1; k--) begin
      for (int i = 0; i < WIDTH; i++) begin
        if ((i >= (1 << k)) && (((i + 1) % (1 << k)) == (1 << (k - 1)))) begin
          gd[i] = gd[i] | (pd[i] & gd[i - (1 << (k - 1))]);
          pd[i] = pd[i] & pd[i - (1 << (k - 1))];
        end
      end
    end
    carry[0] = cin2;
    for (int i = 1; i < WIDTH; i++) begin
      carry[i] = gd[i - 1] | (pd[i - 1] & cin2);
    end
    cout_c = gd[WIDTH - 1] | (pd[WIDTH - 1] & cin2);
    ovf_c  = carry[WIDTH - 1] ^ cout_c;
    sum_c  = pb2 ^ carry;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v3    <= 1'b0;
      sum3  <= '0;
      cout3 <= 1'b0;
      ovf3  <= 1'b0;
      zero3 <= 1'b0;
      tag3  <= '0;
    end else if (adv3) begin
      v3    <= v2;
      sum3  <= sum_c;
      cout3 <= cout_c;
      ovf3  <= ovf_c;
      zero3 <= (sum_c == '0);
      tag3  <= tag2;
    end
  end

  assign out_valid = v3;
  assign sum       = sum3;
  assign cout      = cout3;
  assign ovf       = ovf3;
  assign zero      = zero3;
  assign out_tag   = tag3;

endmodule
